// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the round-robin bus arbiter.
package bus_arb_pkg;

    // FSM encoding, also driven onto the bus interface state field.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGrant   = 3'd1,
        StXfer    = 3'd2,
        StRelease = 3'd3
    } arb_state_t;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after
// ptr_i, searching upward and wrapping NREQ-1 -> 0.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            any_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int off = int'(NREQ) - 1; off >= 0; off--) begin
            cand = IdxW'((int'(ptr_i) + off) % int'(NREQ));
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer sharing one address/data bus among NREQ
// requesters, with a per-tenure hold timeout.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          done_i,
    input  logic [NREQ*AW-1:0]       addr_in_i,
    input  logic [NREQ*DW-1:0]       data_in_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [AW-1:0]            bus_addr_o,
    output logic [DW-1:0]            bus_data_o,
    output logic                     bus_valid_o,
    output logic [$clog2(NREQ)-1:0]  owner_o,
    output logic [2:0]               state_o,
    output logic                     timeout_err_o
);

    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    arb_state_t       state_q;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  owner_q;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [NREQ-1:0]  gnt_q;
    logic             valid_q;

    logic             pick_any;
    logic [IdxW-1:0]  pick_idx;
    logic             owner_end;
    logic             hold_limit;
    logic             timeout;

    rr_picker #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_picker (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Tenure end conditions; owner-initiated release takes precedence over timeout.
    always_comb begin
        owner_end  = done_i[owner_q] | ~req_i[owner_q];
        hold_limit = (hold_q >= HoldW'(MAX_HOLD - 1));
        timeout    = ~owner_end & hold_limit;
        ptr_d      = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        hold_d     = (hold_q == {HoldW{1'b1}}) ? hold_q : hold_q + 1'b1;
    end

    // Arbitration FSM with registered grant and valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    hold_q  <= '0;
                    valid_q <= 1'b1;
                    state_q <= StXfer;
                end
                StXfer: begin
                    hold_q <= hold_d;
                    if (owner_end || timeout) begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    ptr_q   <= ptr_d;
                    state_q <= StIdle;
                end
                default: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bus mux: owner's slice only while transferring, zero otherwise.
    always_comb begin
        bus_addr_o = '0;
        bus_data_o = '0;
        if (state_q == StXfer) begin
            bus_addr_o = addr_in_i[owner_q * AW +: AW];
            bus_data_o = data_in_i[owner_q * DW +: DW];
        end
    end

    // Output wiring; the timeout pulse reacts to done in the same cycle.
    always_comb begin
        gnt_o         = gnt_q;
        bus_valid_o   = valid_q;
        owner_o       = owner_q;
        state_o       = state_q;
        timeout_err_o = (state_q == StXfer) & timeout;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected bus beats, a
// negedge monitor pops one per bus_valid cycle.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        bus_valid;
    logic [1:0]  owner;
    logic [2:0]  state;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] owner;
        logic [3:0] gnt;
        logic [7:0] addr;
        logic [7:0] data;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [7:0] addr_tab [4] = '{8'h10, 8'hA5, 8'hC2, 8'hD3};
    logic [7:0] data_tab [4] = '{8'h11, 8'h3C, 8'h66, 8'h77};
    int         rr_owner [5] = '{0, 1, 2, 3, 0};

    bus_arbiter #(
        .NREQ     (4),
        .MAX_HOLD (8),
        .AW       (8),
        .DW       (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .done_i        (done),
        .addr_in_i     (addr_in),
        .data_in_i     (data_in),
        .gnt_o         (gnt),
        .bus_addr_o    (bus_addr),
        .bus_data_o    (bus_data),
        .bus_valid_o   (bus_valid),
        .owner_o       (owner),
        .state_o       (state),
        .timeout_err_o (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic terr);
        exp_t e;
        e.owner = 2'(k);
        e.gnt   = 4'b0001 << k;
        e.addr  = addr_tab[k];
        e.data  = data_tab[k];
        e.terr  = terr;
        exp_q.push_back(e);
    endtask

    // Bounded wait for a state; an expired bound shows as a failed check.
    task automatic wait_state(input logic [2:0] s, input string name, output int n);
        n = 0;
        while (state !== s && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    // Monitor: one expected beat per bus_valid cycle.
    always @(negedge clk) begin
        if (rst_n && bus_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_valid: got owner %0d with no expected beat", owner);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_owner", 32'(owner), 32'(mon_e.owner));
                chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
                chk("sb_addr", 32'(bus_addr), 32'(mon_e.addr));
                chk("sb_data", 32'(bus_data), 32'(mon_e.data));
                chk("sb_terr", 32'(timeout_err), 32'(mon_e.terr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        req     = '0;
        done    = '0;
        addr_in = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        data_in = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        #20 rst_n = 1'b1;

        // Single requester, done after three transfer cycles.
        tick();
        req = 4'b0010;
        tick();
        chk("single_grant_state", 32'(state), 1);
        chk("single_grant_gnt", 32'(gnt), 32'h2);
        chk("single_grant_valid", 32'(bus_valid), 0);
        repeat (3) push(1, 1'b0);
        tick();
        tick();
        tick();
        done = 4'b0010;
        tick();
        chk("single_release_state", 32'(state), 3);
        chk("single_release_gnt", 32'(gnt), 0);
        chk("single_release_valid", 32'(bus_valid), 0);
        done = '0;
        req  = '0;
        tick();
        chk("single_idle_state", 32'(state), 0);

        // Asynchronous reset while requester 2 owns the bus.
        req = 4'b0100;
        wait_state(3'd2, "rstx_reach_xfer", n);
        chk("rstx_owner", 32'(owner), 2);
        rst_n = 1'b0;
        #1;
        chk("rstx_gnt", 32'(gnt), 0);
        chk("rstx_valid", 32'(bus_valid), 0);
        chk("rstx_state", 32'(state), 0);
        chk("rstx_addr", 32'(bus_addr), 0);
        req = 4'b1111;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Round-robin rotation from ptr 0 with all requesters active.
        for (int t = 0; t < 5; t++) begin
            wait_state(3'd2, "rr_reach_xfer", n);
            if (t > 0) chk("rr_gap", 32'(n), 3);
            push(rr_owner[t], 1'b0);
            done = 4'b1111;
            tick();
            done = '0;
            if (t == 4) req = '0;
            chk("rr_release", 32'(state), 3);
        end
        tick();
        chk("rr_idle", 32'(state), 0);

        // Hold timeout: requester 3 never finishes.
        req = 4'b1000;
        wait_state(3'd2, "to_reach_xfer", n);
        repeat (7) push(3, 1'b0);
        push(3, 1'b1);
        repeat (7) tick();
        chk("to_last_xfer_state", 32'(state), 2);
        chk("to_last_xfer_terr", 32'(timeout_err), 1);
        tick();
        chk("to_release_state", 32'(state), 3);
        chk("to_release_terr", 32'(timeout_err), 0);
        req = '0;
        tick();
        chk("to_idle_state", 32'(state), 0);

        // done coinciding with the final hold cycle suppresses the timeout.
        req = 4'b0100;
        wait_state(3'd2, "coin_reach_xfer", n);
        repeat (8) push(2, 1'b0);
        repeat (7) tick();
        done = 4'b0100;
        #1;
        chk("coin_terr", 32'(timeout_err), 0);
        tick();
        chk("coin_release_state", 32'(state), 3);
        done = '0;
        req  = '0;
        tick();

        // Wrap-around: owner 3 releases, requester 0 wins next.
        req = 4'b1001;
        wait_state(3'd2, "wrap_reach_xfer", n);
        chk("wrap_first_owner", 32'(owner), 3);
        push(3, 1'b0);
        done = 4'b1000;
        tick();
        done = '0;
        chk("wrap_release_state", 32'(state), 3);
        tick();
        tick();
        chk("wrap_next_owner", 32'(owner), 0);
        chk("wrap_next_gnt", 32'(gnt), 32'h1);
        push(0, 1'b0);
        tick();
        done = 4'b0001;
        tick();
        done = '0;
        req  = '0;
        chk("wrap_done_release", 32'(state), 3);
        tick();

        // Request withdrawn during GRANT: one transfer beat, then release.
        req = 4'b0010;
        wait_state(3'd1, "drop_reach_grant", n);
        req = '0;
        push(1, 1'b0);
        tick();
        chk("drop_xfer_valid", 32'(bus_valid), 1);
        tick();
        chk("drop_release_state", 32'(state), 3);
        chk("drop_release_valid", 32'(bus_valid), 0);
        repeat (3) tick();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
